// File: rtl/imem_loader_pkg.sv
// Shared state encoding and framing constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (see imem_loader.sv).
package imem_loader_pkg;

   typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, RUN, ERR} state_e;

   localparam logic [2:0] ST_HDR0 = HDR0;
   localparam logic [2:0] ST_HDR1 = HDR1;
   localparam logic [2:0] ST_DATA = DATA;
   localparam logic [2:0] ST_CHK  = CHK;
   localparam logic [2:0] ST_RUN  = RUN;
   localparam logic [2:0] ST_ERR  = ERR;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int CNT_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = host/byte source and memory side, slave = the loader itself.
interface imem_loader_if #(parameter int ADDR_W = 16);

   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;

   modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
   modport slave  (input in_valid, in_data, output in_ready, we, waddr, wdata);

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs bytes MSB-first into 32-bit words and registers a one-cycle write strobe
// on the fourth byte; clr drops any partial word.
module word_packer
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              byte_vld,
   input  logic [7:0]        byte_in,
   input  logic [ADDR_W-1:0] word_idx,
   output logic              word_done,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata
);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [23:0]       asm_q, asm_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;

   always_comb begin
      cnt_d     = cnt_q;
      asm_d     = asm_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      word_done = byte_vld && (cnt_q == CNT_W'(WORD_BYTES - 1));
      if (clr) begin
         cnt_d = '0;
         asm_d = '0;
      end else if (byte_vld) begin
         cnt_d = cnt_q + CNT_W'(1);
         asm_d = {asm_q[15:0], byte_in};
         if (word_done) begin
            we_d    = 1'b1;
            waddr_d = word_idx;
            wdata_d = {asm_q, byte_in};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   // A strobe registered just before reset must not reach memory during reset.
   assign we    = we_q & ~rst;
   assign waddr = waddr_q;
   assign wdata = wdata_q;

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: header capture, length check, word index and FSM.
// Define IMEM_LOADER_CHECKSUM_EN to require a mod-256 payload-sum trailer byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   imem_loader_if.slave bus,
   input  logic        reload,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   logic [2:0]        state_q, state_d;
   logic [7:0]        len_hi_q, len_hi_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              done_q, done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   logic        fire, all_written, data_fire, word_done;
   logic [15:0] hdr_len;

   assign bus.in_ready = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                         (state_q == ST_DATA) || (state_q == ST_CHK);
   assign fire         = bus.in_valid && bus.in_ready;
   assign hdr_len      = {len_hi_q, bus.in_data};
   assign all_written  = (32'(idx_q) == 32'(len_q));
   // Without a trailer, DATA lingers one cycle after the last byte so the final
   // write lands before cpu_hold drops; a byte taken then is past the frame.
   assign data_fire    = fire && (state_q == ST_DATA) && !all_written;

   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      len_d    = len_q;
      idx_d    = idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      case (state_q)
         ST_HDR0: if (fire) begin
            len_hi_d = bus.in_data;
            state_d  = ST_HDR1;
         end
         ST_HDR1: if (fire) begin
            len_d = hdr_len;
            idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d = '0;
`endif
            if (32'(hdr_len) > 32'(DEPTH))
               state_d = ST_ERR;
            else if (hdr_len == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = ST_CHK;
`else
               state_d = ST_RUN;
`endif
            else
               state_d = ST_DATA;
         end
         ST_DATA: begin
            if (all_written)
               state_d = ST_RUN;
            else if (word_done) begin
               idx_d = idx_q + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (32'(idx_q) + 32'd1 == 32'(len_q))
                  state_d = ST_CHK;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (data_fire)
               sum_d = sum_q + bus.in_data;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: if (fire)
            state_d = (bus.in_data == sum_q) ? ST_RUN : ST_ERR;
`endif
         ST_RUN, ST_ERR: if (reload)
            state_d = ST_HDR0;
         default: state_d = ST_HDR0;
      endcase
      done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_HDR0;
         len_hi_q <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         done_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         len_hi_q <= len_hi_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         done_q   <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

   word_packer #(.ADDR_W(ADDR_W)) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (state_q != ST_DATA),
      .byte_vld  (data_fire),
      .byte_in   (bus.in_data),
      .word_idx  (idx_q),
      .word_done (word_done),
      .we        (bus.we),
      .waddr     (bus.waddr),
      .wdata     (bus.wdata)
   );

   assign cpu_hold = (state_q != ST_RUN);
   assign error    = (state_q == ST_ERR);
   assign done     = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; builds with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic reload = 1'b0;
   logic cpu_hold, done, error;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus();

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .reload   (reload),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [ADDR_W-1:0] wa[$];
   logic [31:0]       wd[$];
   int                wc[$];
   int                done_cnt = 0, done_cyc = 0, fall_cyc = 0;
   logic              hold_prev = 1'b1;

   always @(negedge clk) begin
      if (bus.we) begin
         wa.push_back(bus.waddr);
         wd.push_back(bus.wdata);
         wc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (hold_prev && !cpu_hold) fall_cyc = cyc;
      hold_prev = cpu_hold;
   end

   int n_vec = 0, n_bad = 0;
   int base, d0;
   logic [7:0] fb[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int i = 0; i < 100 && !ok; i++) begin
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) check("byte_timeout", 64'd0, 64'd1);
   endtask

   // Sends fb as-is; with_trailer appends the payload sum when checksum is built in.
   task automatic send_fb(input bit gap, input bit with_trailer);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < fb.size(); i++) begin
         if (i >= 2) s = s + fb[i];
         send_byte(fb[i]);
         if (gap) tick(1);
      end
      if (CK && with_trailer) begin
         send_byte(s);
         if (gap) tick(1);
      end
   endtask

   task automatic do_reload();
      reload = 1'b1;
      tick(1);
      reload = 1'b0;
      check("reload_hold", 64'(cpu_hold), 64'd1);
      check("reload_rdy", 64'(bus.in_ready), 64'd1);
      check("reload_err", 64'(error), 64'd0);
   endtask

   task automatic mark();
      base = wa.size();
      d0   = done_cnt;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      tick(3);
      check("rst_we", 64'(bus.we), 64'd0);
      check("rst_waddr", 64'(bus.waddr), 64'd0);
      check("rst_wdata", 64'(bus.wdata), 64'd0);
      check("rst_hold", 64'(cpu_hold), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(error), 64'd0);
      rst = 1'b0;
      tick(1);
      check("rst_rdy", 64'(bus.in_ready), 64'd1);

      // N=2 streamed back-to-back
      mark();
      fb = {8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h08};
      send_fb(1'b0, 1'b1);
      tick(6);
      check("t1_nwr", 64'(wa.size() - base), 64'd2);
      if (wa.size() >= base + 2) begin
         check("t1_a0", 64'(wa[base]), 64'd0);
         check("t1_d0", 64'(wd[base]), 64'h24010005);
         check("t1_a1", 64'(wa[base+1]), 64'd1);
         check("t1_d1", 64'(wd[base+1]), 64'hAC010008);
         check("t1_gap", 64'(wc[base+1] - wc[base]), 64'd4);
         check("t1_fall", 64'(fall_cyc - wc[base+1]), 64'd1);
      end
      check("t1_done", 64'(done_cnt - d0), 64'd1);
      check("t1_donecyc", 64'(done_cyc), 64'(fall_cyc));
      check("t1_hold", 64'(cpu_hold), 64'd0);
      check("t1_rdy", 64'(bus.in_ready), 64'd0);

      // same image, in_valid every other cycle
      do_reload();
      mark();
      send_fb(1'b1, 1'b1);
      tick(6);
      check("t2_nwr", 64'(wa.size() - base), 64'd2);
      if (wa.size() >= base + 2) begin
         check("t2_a0", 64'(wa[base]), 64'd0);
         check("t2_d0", 64'(wd[base]), 64'h24010005);
         check("t2_a1", 64'(wa[base+1]), 64'd1);
         check("t2_d1", 64'(wd[base+1]), 64'hAC010008);
         check("t2_gap", 64'(wc[base+1] - wc[base]), 64'd8);
         check("t2_after", 64'(fall_cyc > wc[base+1]), 64'd1);
      end
      check("t2_done", 64'(done_cnt - d0), 64'd1);

      // N=257 exceeds DEPTH
      do_reload();
      mark();
      fb = {8'h01, 8'h01};
      send_fb(1'b0, 1'b0);
      tick(3);
      check("t3_err", 64'(error), 64'd1);
      check("t3_rdy", 64'(bus.in_ready), 64'd0);
      check("t3_hold", 64'(cpu_hold), 64'd1);
      check("t3_nwr", 64'(wa.size() - base), 64'd0);
      check("t3_done", 64'(done_cnt - d0), 64'd0);
      do_reload();

      // reset mid-word, then a clean N=1 frame
      mark();
      fb = {8'h00, 8'h01, 8'h12, 8'h34};
      send_fb(1'b0, 1'b0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      check("t4_rstnwr", 64'(wa.size() - base), 64'd0);
      check("t4_rstrdy", 64'(bus.in_ready), 64'd1);
      fb = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_fb(1'b0, 1'b1);
      tick(6);
      check("t4_nwr", 64'(wa.size() - base), 64'd1);
      if (wa.size() >= base + 1) begin
         check("t4_a0", 64'(wa[base]), 64'd0);
         check("t4_d0", 64'(wd[base]), 64'hDEADBEEF);
      end
      check("t4_hold", 64'(cpu_hold), 64'd0);

      // zero-length image
      do_reload();
      mark();
      fb = {8'h00, 8'h00};
      send_fb(1'b0, 1'b1);
      tick(4);
      check("t5_nwr", 64'(wa.size() - base), 64'd0);
      check("t5_done", 64'(done_cnt - d0), 64'd1);
      check("t5_hold", 64'(cpu_hold), 64'd0);
      check("t5_err", 64'(error), 64'd0);

      // full-depth image: bytes 0..1023 mod 256
      do_reload();
      mark();
      fb = {8'h01, 8'h00};
      for (int i = 0; i < 4 * DEPTH; i++) fb.push_back(8'(i));
      send_fb(1'b0, 1'b1);
      tick(6);
      check("t6_nwr", 64'(wa.size() - base), 64'd256);
      if (wa.size() >= base + 256) begin
         check("t6_d0", 64'(wd[base]), 64'h00010203);
         check("t6_alast", 64'(wa[base+255]), 64'd255);
         check("t6_dlast", 64'(wd[base+255]), 64'hFCFDFEFF);
      end
      check("t6_hold", 64'(cpu_hold), 64'd0);
      check("t6_done", 64'(done_cnt - d0), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      do_reload();
      mark();
      fb = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      send_fb(1'b0, 1'b0);
      tick(4);
      check("c1_err", 64'(error), 64'd0);
      check("c1_hold", 64'(cpu_hold), 64'd0);
      check("c1_nwr", 64'(wa.size() - base), 64'd1);

      do_reload();
      mark();
      fb = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
      send_fb(1'b0, 1'b0);
      tick(4);
      check("c2_err", 64'(error), 64'd1);
      check("c2_hold", 64'(cpu_hold), 64'd1);
      check("c2_nwr", 64'(wa.size() - base), 64'd1);
      if (wa.size() >= base + 1)
         check("c2_d0", 64'(wd[base]), 64'h01020304);
      check("c2_done", 64'(done_cnt - d0), 64'd0);

      do_reload();
      fb = {8'h00, 8'h00, 8'h01};
      send_fb(1'b0, 1'b0);
      tick(3);
      check("c3_err", 64'(error), 64'd1);
      do_reload();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
